// File: rtl/div_ctrl.sv
// Control wrapper around an external unsigned divider: handles signed operand
// folding, RISC-V divide-by-zero and overflow cases, result fix-up and flush/drain.
module div_ctrl #(
  parameter int DRAIN_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_tag,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_tag,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_enabled,
  input  logic [31:0] div_c,
  input  logic        div_completed
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_FIX   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int               CNT_W      = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [2:0]       state_q,     state_d;
  logic             is_rem_q,    is_rem_d;
  logic [4:0]       tag_q,       tag_d;
  logic [31:0]      div_a_q,     div_a_d;
  logic [31:0]      div_b_q,     div_b_d;
  logic             neg_quo_q,   neg_quo_d;
  logic             neg_rem_q,   neg_rem_d;
  logic [31:0]      quot_q,      quot_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             div_en_q,    div_en_d;

  logic        accept;
  logic        req_signed;
  logic        req_is_rem;
  logic        rs1_neg;
  logic        rs2_neg;
  logic [31:0] abs_rs1;
  logic [31:0] abs_rs2;
  logic        div_by_zero;
  logic        overflow;
  logic [31:0] special_data;
  logic [31:0] quot_fix;
  logic [31:0] prod;
  logic [31:0] rem_raw;
  logic [31:0] rem_fix;

  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // Operand decode: op[0] selects unsigned, op[1] selects remainder.
  assign req_signed   = ~req_op[0];
  assign req_is_rem   = req_op[1];
  assign rs1_neg      = req_signed & req_rs1[31];
  assign rs2_neg      = req_signed & req_rs2[31];
  assign abs_rs1      = rs1_neg ? (32'd0 - req_rs1) : req_rs1;
  assign abs_rs2      = rs2_neg ? (32'd0 - req_rs2) : req_rs2;
  assign div_by_zero  = (req_rs2 == 32'd0);
  assign overflow     = req_signed && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
  assign special_data = div_by_zero ? (req_is_rem ? req_rs1 : 32'hFFFF_FFFF)
                                    : (req_is_rem ? 32'd0   : 32'h8000_0000);

  // Remainder is rebuilt from the unsigned quotient so the divider need only return one value.
  assign quot_fix = neg_quo_q ? (32'd0 - quot_q) : quot_q;
  assign prod     = quot_q * div_b_q;
  assign rem_raw  = div_a_q - prod;
  assign rem_fix  = neg_rem_q ? (32'd0 - rem_raw) : rem_raw;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    is_rem_d    = is_rem_q;
    tag_d       = tag_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quot_d      = quot_q;
    resp_data_d = resp_data_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d  = req_is_rem;
          tag_d     = req_tag;
          div_a_d   = abs_rs1;
          div_b_d   = abs_rs2;
          neg_quo_d = rs1_neg ^ rs2_neg;
          neg_rem_d = rs1_neg;
          if (div_by_zero || overflow) begin
            resp_data_d = special_data;
            state_d     = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) begin
          drain_cnt_d = DRAIN_LOAD;
          state_d     = S_DRAIN;
        end else if (div_completed) begin
          quot_d  = div_c;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          resp_data_d = is_rem_q ? rem_fix : quot_fix;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Leave when the count would reach zero, so DRAIN lasts exactly DRAIN_CYCLES cycles.
        if (drain_cnt_q <= CNT_ONE) begin
          drain_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    div_en_d = (state_d == S_ISSUE);
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop is reset, there is no memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_rem_q    <= 1'b0;
      tag_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quot_q      <= '0;
      resp_data_q <= '0;
      drain_cnt_q <= '0;
      div_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_rem_q    <= is_rem_d;
      tag_q       <= tag_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quot_q      <= quot_d;
      resp_data_q <= resp_data_d;
      drain_cnt_q <= drain_cnt_d;
      div_en_q    <= div_en_d;
    end
  end

  assign resp_valid  = (state_q == S_RESP);
  assign resp_data   = resp_data_q;
  assign resp_tag    = tag_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_enabled = div_en_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboarded responses, a behavioural
// unsigned divider with programmable latency, flush/drain and reset scenarios.
module tb_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_tag;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_enabled;
  logic [31:0] div_c;
  logic        div_completed;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  int div_latency;
  int lat_cnt;
  int comp_edge;
  int en_rises;
  int en_fall_edge;
  int rv_rise_edge;
  int acc_edge;
  bit en_prev;
  bit rv_prev;
  bit hold_vld;
  logic [31:0] hold_data;
  logic [4:0]  hold_tag;

  div_ctrl #(.DRAIN_CYCLES(40)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_tag      (req_tag),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_tag     (resp_tag),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_enabled  (div_enabled),
    .div_c        (div_c),
    .div_completed(div_completed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb_;
    sa  = a;
    sb_ = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      OP_DIV:  return sa / sb_;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb_;
      default: return a % b;
    endcase
  endfunction

  // Downstream unsigned divider: answers div_latency cycles after enable, holds until enable falls.
  initial begin
    div_completed = 1'b0;
    div_c         = '0;
    lat_cnt       = 0;
    comp_edge     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !div_enabled) begin
        div_completed = 1'b0;
        lat_cnt       = 0;
      end else if (!div_completed) begin
        lat_cnt++;
        if (lat_cnt >= div_latency) begin
          div_completed = 1'b1;
          div_c         = (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
          comp_edge     = cyc;
        end
      end
    end
  end

  // Edge monitor: records the edge after which enable/valid changed.
  initial begin
    en_prev = 1'b0; rv_prev = 1'b0;
    en_rises = 0; en_fall_edge = 0; rv_rise_edge = 0;
    forever begin
      @(posedge clk);
      #1;
      if (div_enabled && !en_prev) en_rises++;
      if (!div_enabled && en_prev) en_fall_edge = cyc;
      if (resp_valid && !rv_prev) rv_rise_edge = cyc;
      en_prev = div_enabled;
      rv_prev = resp_valid;
    end
  end

  // Response scoreboard and hold-stability monitor.
  initial begin
    exp_t e;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (hold_vld) begin
          check("resp_data_stable", resp_data, hold_data);
          check("resp_tag_stable", 32'(resp_tag), 32'(hold_tag));
        end
        if (resp_ready && !flush) begin
          hold_vld = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("resp_data", resp_data, e.data);
            check("resp_tag", 32'(resp_tag), 32'(e.tag));
          end
        end else begin
          hold_vld  = 1'b1;
          hold_data = resp_data;
          hold_tag  = resp_tag;
        end
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input bit push);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    if (push) begin
      e.data = ref_result(op, a, b);
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    acc_edge  = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end else begin
      check("ready_after_resp", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic wait_completed();
    int n = 0;
    while (!div_completed && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!div_completed) check("complete_timeout", 32'(div_completed), 32'd1);
  endtask

  task automatic count_drain(input string tag, input int exp_len);
    int n = 1;
    check({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    while (n < 200) begin
      @(posedge clk); #1;
      if (req_ready) break;
      n++;
    end
    check({tag, "_len"}, 32'(n), 32'(exp_len));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_div_enabled"}, 32'(div_enabled), 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_resp_tag"}, 32'(resp_tag), 32'd0);
    check({tag, "_div_a"}, div_a, 32'd0);
    check({tag, "_div_b"}, div_b, 32'd0);
  endtask

  initial begin
    int en0;
    logic [31:0] a;
    logic [31:0] b;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    flush = 1'b0; resp_ready = 1'b1; div_latency = 4;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    #1;
    check("ready_after_por", 32'(req_ready), 32'd1);

    // Signed divide and remainder of a negative dividend.
    do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    check("div_a_abs", div_a, 32'd7);
    check("div_b_abs", div_b, 32'd2);
    wait_done();
    check("div_en_fall", 32'(en_fall_edge), 32'(comp_edge + 1));
    check("resp_rise", 32'(rv_rise_edge), 32'(comp_edge + 2));
    do_req(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
    wait_done();

    // Divide by zero and signed overflow bypass the divider.
    en0 = en_rises;
    do_req(OP_DIVU, 32'd100, 32'd0, 5'd5, 1'b1);
    wait_done();
    check("dz_latency", 32'(rv_rise_edge), 32'(acc_edge));
    do_req(OP_REMU, 32'd100, 32'd0, 5'd6, 1'b1);
    wait_done();
    do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1);
    wait_done();
    check("ovf_latency", 32'(rv_rise_edge), 32'(acc_edge));
    do_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    wait_done();
    check("special_no_enable", 32'(en_rises), 32'(en0));

    // Long divider latency with consumer back-pressure.
    div_latency = 36;
    resp_ready  = 1'b0;
    do_req(OP_REMU, 32'hFFFF_FFFF, 32'd10, 5'd9, 1'b1);
    begin
      int n = 0;
      while (!resp_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    repeat (5) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_done();
    check("bp_div_en_fall", 32'(en_fall_edge), 32'(comp_edge + 1));
    check("bp_resp_rise", 32'(rv_rise_edge), 32'(comp_edge + 2));

    // Flush mid-division: divider dropped, drain window, no response.
    div_latency = 60;
    do_req(OP_DIVU, 32'd1000, 32'd7, 5'd10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_en", 32'(div_enabled), 32'd0);
    count_drain("drain", 40);
    div_latency = 3;
    do_req(OP_DIVU, 32'd9, 32'd3, 5'd11, 1'b1);
    wait_done();

    // Flush wins over a completion in the same cycle.
    div_latency = 5;
    do_req(OP_DIV, 32'd50, 32'hFFFF_FFFB, 5'd12, 1'b0);
    wait_completed();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("prio_div_en", 32'(div_enabled), 32'd0);
    count_drain("prio_drain", 40);

    // Flush during FIX and during RESP return straight to IDLE.
    do_req(OP_DIV, 32'd77, 32'd5, 5'd13, 1'b0);
    wait_completed();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fix_flush_valid", 32'(resp_valid), 32'd0);
    check("fix_flush_ready", 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
    do_req(OP_DIVU, 32'd5, 32'd0, 5'd14, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    resp_ready = 1'b1;
    check("resp_flush_valid", 32'(resp_valid), 32'd0);
    check("resp_flush_ready", 32'(req_ready), 32'd1);

    // Mixed random operations.
    for (int i = 0; i < 12; i++) begin
      div_latency = int'($urandom_range(1, 6));
      a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 2000) - 32'd1000);
      b = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 40) - 32'd20);
      do_req(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), 1'b1);
      wait_done();
    end

    // Asynchronous reset in the middle of a division.
    div_latency = 30;
    do_req(OP_DIV, 32'd12345, 32'd67, 5'd15, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_midrst", 32'(req_ready), 32'd1);
    div_latency = 4;
    do_req(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd16, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
